// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_pkg: shared types for the data-memory result read-back path        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dm_pkg;

  localparam int DM_AW        = 8;
  localparam int DM_DW        = 8;
  localparam int DM_BUF_DEPTH = 2;

  typedef logic [DM_AW-1:0] dm_addr_t;
  typedef logic [DM_DW-1:0] dm_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } streamer_state_t;

endpackage
`default_nettype wire

// File: rtl/rd_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rd_skid_fifo: small output buffer absorbing read data during stalls   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rd_skid_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = DM_BUF_DEPTH,
  parameter int DW    = DM_DW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [DW-1:0]                wdata_i,
  input  logic                         pop_i,
  output logic [DW-1:0]                rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_i) rptr_q <= ptr_inc(rptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/dm_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_result_streamer: on rising done, streams a memory window out as    |
// | valid/ready bytes. Rev 1.0                                            |
// +----------------------------------------------------------------------+
module dm_result_streamer
  import dm_pkg::*;
#(
  parameter int AW        = DM_AW,
  parameter int DW        = DM_DW,
  parameter int BUF_DEPTH = DM_BUF_DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          done_i,
  input  logic [AW-1:0] rd_base_i,
  input  logic [AW:0]   rd_len_i,
  output logic          mem_rd_en_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          dump_done_o
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  streamer_state_t state_q;
  logic            done_q, busy_q, zero_done_q, inflight_q;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     issue_cnt_q, send_cnt_q;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     committed;
  logic            trigger, accept, last_accept, issue;

  assign trigger     = (state_q == IDLE) && done_i && !done_q;
  assign out_valid_o = (fifo_cnt != '0);
  assign accept      = out_valid_o && out_ready_i;
  assign out_last_o  = out_valid_o && (send_cnt_q == (AW+1)'(1));
  assign last_accept = accept && out_last_o;

  // The beat leaving this cycle frees its slot before a new read can land.
  always_comb begin
    committed = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
    if (accept) committed = committed - (CW+1)'(1);
  end

  assign issue = (state_q == RUN) && (issue_cnt_q != '0) &&
                 (committed < (CW+1)'(BUF_DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      zero_done_q <= 1'b0;
      inflight_q  <= 1'b0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
    end else begin
      done_q      <= done_i;
      zero_done_q <= 1'b0;
      inflight_q  <= issue;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            addr_q      <= rd_base_i;
            issue_cnt_q <= rd_len_i;
            send_cnt_q  <= rd_len_i;
            if (rd_len_i == '0) begin
              state_q     <= FIN;
              zero_done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q      <= addr_q + AW'(1);
            issue_cnt_q <= issue_cnt_q - (AW+1)'(1);
          end
          if (accept) send_cnt_q <= send_cnt_q - (AW+1)'(1);
          if (last_accept) begin
            busy_q  <= 1'b0;
            state_q <= FIN;
          end
        end
        FIN: begin
          if (!done_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rd_skid_fifo #(
    .DEPTH (BUF_DEPTH),
    .DW    (DW)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .wdata_i (mem_rdata_i),
    .pop_i   (accept),
    .rdata_o (out_data_o),
    .count_o (fifo_cnt)
  );

  assign mem_rd_en_o = issue;
  assign mem_addr_o  = addr_q;
  assign busy_o      = busy_q;
  assign dump_done_o = zero_done_q || last_accept;

endmodule
`default_nettype wire

// File: tb/tb_dm_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dm_result_streamer: scoreboard bench for dm_result_streamer        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dm_result_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [7:0] rd_base;
  logic [8:0] rd_len;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       dump_done;

  always #5 clk = ~clk;

  dm_result_streamer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .done_i      (done),
    .rd_base_i   (rd_base),
    .rd_len_i    (rd_len),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .dump_done_o (dump_done)
  );

  logic [7:0] mem [256];
  logic [8:0] exp_q [$];   // {last, data}
  logic [7:0] addr_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;
  int cur_len = 0;
  int dd_seen = 0;
  int iss_seen = 0;
  int acc_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Registered-read memory: address sampled with the strobe, data one edge later.
  initial begin
    logic       en;
    logic [7:0] a;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      en = mem_rd_en;
      a  = mem_addr;
      @(posedge clk);
      #1;
      if (en) mem_rdata = mem[a];
    end
  end

  initial begin
    int ph;
    logic [5:0] pat;
    ph  = 0;
    pat = 6'b101001;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          out_ready = pat[ph];
          ph = (ph + 1) % 6;
        end
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic pv, pr, pl, acc;
    logic [7:0] pd;
    logic [8:0] e;
    logic [7:0] ea;
    int iss_tot, acc_tot;
    pv = 0; pr = 0; pl = 0; pd = '0; iss_tot = 0; acc_tot = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; iss_tot = 0; acc_tot = 0;
      end else begin
        acc = out_valid && out_ready;
        if (pv && !pr) begin
          chk("stall_valid_held", out_valid, 1);
          if (out_valid) begin
            chk("stall_data_stable", out_data, pd);
            chk("stall_last_stable", out_last, pl);
          end
        end
        if (out_valid) chk("busy_while_valid", busy, 1);
        if (acc) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_data", out_data, e[7:0]);
            chk("beat_last", out_last, e[8]);
          end
          acc_tot++;
          acc_seen++;
        end
        if (mem_rd_en) begin
          chk("issue_room", (iss_tot - acc_tot) < 2, 1);
          if (addr_q.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            ea = addr_q.pop_front();
            chk("issue_addr", mem_addr, ea);
          end
          iss_tot++;
          iss_seen++;
        end
        if (dump_done) dd_seen++;
        if (cur_len != 0 && (dump_done || (acc && out_last)))
          chk("dump_done_on_last", dump_done, acc && out_last);
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
    end
  end

  task automatic run_dump(input int base, input int len, input int mode, input int hold);
    int  n;
    bit  got;
    ready_mode = mode;
    done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), mem[(base + i) % 256]});
      addr_q.push_back(8'((base + i) % 256));
    end
    cur_len  = len;
    dd_seen  = 0;
    iss_seen = 0;
    rd_base  = 8'(base);
    rd_len   = 9'(len);
    done     = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < len * 6 + 40) begin
      @(negedge clk);
      #1;
      n++;
      if (n == 1) begin
        rd_base = 8'($urandom);
        rd_len  = 9'($urandom);
      end
      if (dd_seen != 0) got = 1;
    end
    chk("dump_done_seen", got, 1);
    if (got && mode == 0) chk("dump_cycles", n, (len == 0) ? 1 : len + 2);
    repeat (hold + 3) @(negedge clk);
    #1;
    chk("dump_done_once", dd_seen, 1);
    chk("issue_count", iss_seen, len);
    chk("all_beats_out", exp_q.size(), 0);
    chk("busy_cleared", busy, 0);
    done = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; done = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dump_done", dump_done, 0);
    #1 rst_n = 1'b1;

    mem[2] = 8'hF1;
    run_dump(2, 1, 0, 0);
    mem[0] = 8'hF0; mem[1] = 8'hCC; mem[2] = 8'hC3; mem[3] = 8'h55;
    run_dump(0, 4, 0, 0);
    run_dump(0, 4, 2, 0);
    mem[254] = 8'hA1; mem[255] = 8'hA2; mem[0] = 8'hA3; mem[1] = 8'hA4;
    run_dump(254, 4, 0, 0);
    run_dump(7, 0, 0, 20);
    run_dump(9, 1, 0, 0);

    // Reset in the middle of a 4-byte dump, then a clean re-run.
    mem[0] = 8'hF0; mem[1] = 8'hCC; mem[2] = 8'hC3; mem[3] = 8'h55;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), mem[i]});
      addr_q.push_back(8'(i));
    end
    cur_len = 4; acc_seen = 0; rd_base = 8'd0; rd_len = 9'd4; done = 1'b1;
    n = 0;
    while (acc_seen < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_dump_reached", acc_seen >= 2, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_mem_rd_en", mem_rd_en, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dump_done", dump_done, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    exp_q.delete();
    addr_q.delete();
    done = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_dump(0, 4, 0, 0);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 12; t++)
      run_dump($urandom_range(0, 255), $urandom_range(1, 24), 1, $urandom_range(0, 4));
    run_dump($urandom_range(0, 255), 256, 0, 0);
    run_dump($urandom_range(0, 255), 40, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
